// File: rtl/screen_arbiter_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | screen_arbiter_pkg: shared state encoding and defaults. Rev 1.0   |
// +-------------------------------------------------------------------+
package screen_arbiter_pkg;

    localparam int DEFAULT_WIDTH        = 8;
    localparam int DEFAULT_COLOUR_WIDTH = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_START   = 2'd1,
        S_BUSY    = 2'd2,
        S_RELEASE = 2'd3
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/screen_arbiter_rr_picker.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rr_picker: first requester at or after ptr, wrapping. Rev 1.0     |
// +-------------------------------------------------------------------+
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   index,
    output logic               any
);

    // Two passes: indices at/above ptr first, then the wrapped-around lower ones.
    always_comb begin
        winner = '0;
        index  = '0;
        any    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                any       = 1'b1;
                winner[i] = 1'b1;
                index     = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i]) begin
                any       = 1'b1;
                winner[i] = 1'b1;
                index     = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/screen_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | screen_arbiter: round-robin share of one screen_writer. Rev 1.0   |
// +-------------------------------------------------------------------+
module screen_arbiter
    import screen_arbiter_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int COLOUR_WIDTH = DEFAULT_COLOUR_WIDTH
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_start,
    input  logic [NUM_REQ*COLOUR_WIDTH-1:0] req_colour,
    input  logic [NUM_REQ*WIDTH-1:0]        req_x_min,
    input  logic [NUM_REQ*WIDTH-1:0]        req_y_min,
    input  logic [NUM_REQ*WIDTH-1:0]        req_x_range,
    input  logic [NUM_REQ*WIDTH-1:0]        req_y_range,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic [NUM_REQ-1:0]              req_done,
    output logic [WIDTH-1:0]                req_screen_x,
    output logic [WIDTH-1:0]                req_screen_y,
    output logic [COLOUR_WIDTH-1:0]         req_old_colour,
    output logic                            screen_start,
    output logic [COLOUR_WIDTH-1:0]         new_screen_colour,
    output logic [WIDTH-1:0]                screen_x_min,
    output logic [WIDTH-1:0]                screen_y_min,
    output logic [WIDTH-1:0]                screen_x_range,
    output logic [WIDTH-1:0]                screen_y_range,
    input  logic [WIDTH-1:0]                screen_x,
    input  logic [WIDTH-1:0]                screen_y,
    input  logic [COLOUR_WIDTH-1:0]         old_screen_colour,
    input  logic                            screen_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t state, state_next;

    logic [IDX_W-1:0]        ptr;
    logic [IDX_W-1:0]        owner;
    logic [NUM_REQ-1:0]      win_onehot;
    logic [IDX_W-1:0]        win_index;
    logic                    win_any;

    logic [COLOUR_WIDTH-1:0] colour_arr  [NUM_REQ];
    logic [WIDTH-1:0]        x_min_arr   [NUM_REQ];
    logic [WIDTH-1:0]        y_min_arr   [NUM_REQ];
    logic [WIDTH-1:0]        x_range_arr [NUM_REQ];
    logic [WIDTH-1:0]        y_range_arr [NUM_REQ];

    logic [WIDTH-1:0]        sel_x_min, sel_y_min, sel_x_range, sel_y_range;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign colour_arr[g]  = req_colour[g*COLOUR_WIDTH +: COLOUR_WIDTH];
            assign x_min_arr[g]   = req_x_min[g*WIDTH +: WIDTH];
            assign y_min_arr[g]   = req_y_min[g*WIDTH +: WIDTH];
            assign x_range_arr[g] = req_x_range[g*WIDTH +: WIDTH];
            assign y_range_arr[g] = req_y_range[g*WIDTH +: WIDTH];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req    (req_start),
        .ptr    (ptr),
        .winner (win_onehot),
        .index  (win_index),
        .any    (win_any)
    );

    // Region comes from the candidate winner; colour follows the current owner every cycle.
    always_comb begin
        sel_x_min         = '0;
        sel_y_min         = '0;
        sel_x_range       = '0;
        sel_y_range       = '0;
        new_screen_colour = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_onehot[i]) begin
                sel_x_min   = x_min_arr[i];
                sel_y_min   = y_min_arr[i];
                sel_x_range = x_range_arr[i];
                sel_y_range = y_range_arr[i];
            end
            if (req_grant[i]) begin
                new_screen_colour = colour_arr[i];
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (win_any) state_next = S_START;
            S_START:   state_next = S_BUSY;
            S_BUSY:    if (screen_done) state_next = S_RELEASE;
            S_RELEASE: state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ptr            <= '0;
            owner          <= '0;
            req_grant      <= '0;
            req_done       <= '0;
            screen_start   <= 1'b0;
            screen_x_min   <= '0;
            screen_y_min   <= '0;
            screen_x_range <= '0;
            screen_y_range <= '0;
        end else begin
            state        <= state_next;
            screen_start <= (state == S_START);
            req_done     <= '0;
            case (state)
                S_IDLE: begin
                    if (win_any) begin
                        req_grant      <= win_onehot;
                        owner          <= win_index;
                        screen_x_min   <= sel_x_min;
                        screen_y_min   <= sel_y_min;
                        screen_x_range <= sel_x_range;
                        screen_y_range <= sel_y_range;
                    end
                end
                S_BUSY: begin
                    if (screen_done) req_done <= req_grant;
                end
                S_RELEASE: begin
                    req_grant <= '0;
                    ptr       <= IDX_W'(wrap_inc(int'(owner), NUM_REQ));
                end
                default: ;
            endcase
        end
    end

    assign req_screen_x   = screen_x;
    assign req_screen_y   = screen_y;
    assign req_old_colour = old_screen_colour;

endmodule
`default_nettype wire

// File: tb/tb_screen_arbiter.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_screen_arbiter: scoreboard bench with behavioural writer. Rev 1.0 |
// +-------------------------------------------------------------------+
module tb_screen_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int CW = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_start;
    logic [N*CW-1:0] req_colour;
    logic [N*W-1:0]  req_x_min, req_y_min, req_x_range, req_y_range;
    logic [N-1:0]    req_grant, req_done;
    logic [W-1:0]    req_screen_x, req_screen_y;
    logic [CW-1:0]   req_old_colour;
    logic            screen_start;
    logic [CW-1:0]   new_screen_colour;
    logic [W-1:0]    screen_x_min, screen_y_min, screen_x_range, screen_y_range;
    logic [W-1:0]    screen_x, screen_y;
    logic [CW-1:0]   old_screen_colour;
    logic            screen_done;

    logic [W-1:0]    bx [N], by [N], bxr [N], byr [N];
    logic [CW-1:0]   bc [N];
    int              jobs_left [N];

    always #5 clock = ~clock;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_x_min[i*W +: W]    = bx[i];
            req_y_min[i*W +: W]    = by[i];
            req_x_range[i*W +: W]  = bxr[i];
            req_y_range[i*W +: W]  = byr[i];
            req_colour[i*CW +: CW] = bc[i];
        end
    end

    screen_arbiter #(
        .NUM_REQ      (N),
        .WIDTH        (W),
        .COLOUR_WIDTH (CW)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_start         (req_start),
        .req_colour        (req_colour),
        .req_x_min         (req_x_min),
        .req_y_min         (req_y_min),
        .req_x_range       (req_x_range),
        .req_y_range       (req_y_range),
        .req_grant         (req_grant),
        .req_done          (req_done),
        .req_screen_x      (req_screen_x),
        .req_screen_y      (req_screen_y),
        .req_old_colour    (req_old_colour),
        .screen_start      (screen_start),
        .new_screen_colour (new_screen_colour),
        .screen_x_min      (screen_x_min),
        .screen_y_min      (screen_y_min),
        .screen_x_range    (screen_x_range),
        .screen_y_range    (screen_y_range),
        .screen_x          (screen_x),
        .screen_y          (screen_y),
        .old_screen_colour (old_screen_colour),
        .screen_done       (screen_done)
    );

    // Writer model: done pulses (x_range+1)*(y_range+1) cycles after start is seen.
    int   wcnt;
    logic wbusy, wdone, force_done;
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            wbusy <= 1'b0;
            wcnt  <= 0;
            wdone <= 1'b0;
        end else begin
            wdone <= 1'b0;
            if (screen_start) begin
                wbusy <= 1'b1;
                wcnt  <= (int'(screen_x_range) + 1) * (int'(screen_y_range) + 1);
            end else if (wbusy) begin
                if (wcnt == 1) begin
                    wdone <= 1'b1;
                    wbusy <= 1'b0;
                end
                wcnt <= wcnt - 1;
            end
        end
    end
    assign screen_done = wdone | force_done;

    typedef struct {
        logic [N-1:0] who;
        logic [W-1:0] xmin, ymin, xr, yr;
    } job_t;

    job_t         exp_q [$];
    logic [N-1:0] done_q [$];
    int checks = 0, failures = 0;
    int cyc = 0, sd_cyc = -100, overlap = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic upd_req();
        for (int i = 0; i < N; i++) req_start[i] = (jobs_left[i] != 0);
    endtask

    task automatic box(input logic [1:0] i, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] xr, input logic [W-1:0] yr, input logic [CW-1:0] c);
        bx[i] = x; by[i] = y; bxr[i] = xr; byr[i] = yr; bc[i] = c;
    endtask

    task automatic expect_job(input logic [1:0] i);
        job_t e;
        e.who  = N'(1) << i;
        e.xmin = bx[i];
        e.ymin = by[i];
        e.xr   = bxr[i];
        e.yr   = byr[i];
        exp_q.push_back(e);
    endtask

    task automatic tick();
        job_t         e;
        logic [N-1:0] d;
        @(negedge clock);
        cyc++;
        if (!$onehot0(req_grant)) overlap++;
        if (wdone) sd_cyc = cyc;
        if (screen_start) begin
            if (exp_q.size() == 0) begin
                check("start_unexpected", 32'(screen_start), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("grant_owner", 32'(req_grant), 32'(e.who));
                check("x_min", 32'(screen_x_min), 32'(e.xmin));
                check("y_min", 32'(screen_y_min), 32'(e.ymin));
                check("x_range", 32'(screen_x_range), 32'(e.xr));
                check("y_range", 32'(screen_y_range), 32'(e.yr));
                done_q.push_back(e.who);
            end
        end
        if (req_done != '0) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 32'(req_done), 32'd0);
            end else begin
                d = done_q.pop_front();
                check("done_owner", 32'(req_done), 32'(d));
                check("done_latency", 32'(cyc - sd_cyc), 32'd1);
            end
            for (int i = 0; i < N; i++)
                if (req_done[i] && jobs_left[i] > 0) jobs_left[i]--;
            upd_req();
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_q.size() != 0 || req_grant != '0 || req_start != '0)
               && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic tick_until_start(input int budget);
        int n;
        n = 0;
        do begin tick(); n++; end while (!screen_start && n < budget);
        check("start_in_budget", 32'(screen_start), 32'd1);
    endtask

    task automatic clear_all();
        exp_q.delete();
        done_q.delete();
        for (int i = 0; i < N; i++) jobs_left[i] = 0;
        upd_req();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        clear_all();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        force_done        = 1'b0;
        screen_x          = '0;
        screen_y          = '0;
        old_screen_colour = '0;
        for (int i = 0; i < N; i++) box(2'(i), '0, '0, '0, '0, '0);
        clear_all();

        #3;
        check("rst_ctrl", 32'({req_grant, req_done, screen_start}), 32'd0);
        check("rst_region", {screen_x_min, screen_y_min, screen_x_range, screen_y_range}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Single request: start two cycles after req_start, grant clears after done
        box(0, 8'd10, 8'd20, 8'd3, 8'd2, 3'd1);
        expect_job(0);
        jobs_left[0] = 1;
        upd_req();
        tick();
        check("t1_grant_early", 32'(req_grant), 32'b001);
        check("t1_no_start_yet", 32'(screen_start), 32'd0);
        tick();
        check("t1_start_lat", 32'(screen_start), 32'd1);
        check("t1_colour", 32'(new_screen_colour), 32'd1);
        begin
            int n;
            n = 0;
            while (req_done == '0 && n < 100) begin tick(); n++; end
            check("t1_done_seen", 32'(req_done), 32'b001);
        end
        tick();
        check("t1_grant_clear", 32'(req_grant), 32'd0);

        // Both requesting from reset: 0, 1, then 0 again
        do_reset();
        box(0, 8'd1, 8'd2, 8'd1, 8'd1, 3'd2);
        box(1, 8'd3, 8'd4, 8'd1, 8'd0, 3'd3);
        expect_job(0);
        expect_job(1);
        expect_job(0);
        jobs_left[0] = 2;
        jobs_left[1] = 1;
        upd_req();
        wait_idle(200);

        // Owner edits its region mid-job: latched values hold, colour is live
        box(1, 8'd10, 8'd20, 8'd2, 8'd2, 3'd2);
        expect_job(1);
        jobs_left[1] = 1;
        upd_req();
        tick_until_start(10);
        tick();
        tick();
        bx[1] = 8'd99;
        bc[1] = 3'd5;
        screen_x = 8'h3C;
        screen_y = 8'h7E;
        old_screen_colour = 3'd6;
        #1;
        check("t3_xmin_hold", 32'(screen_x_min), 32'd10);
        check("t3_colour_live", 32'(new_screen_colour), 32'd5);
        check("t3_pass_x", 32'(req_screen_x), 32'h3C);
        check("t3_pass_y", 32'(req_screen_y), 32'h7E);
        check("t3_pass_col", 32'(req_old_colour), 32'd6);
        wait_idle(100);

        // Pointer sits at 2: serve 2 (single pixel) then wrap to 0 (x range FF)
        box(2, 8'd5, 8'd6, 8'd0, 8'd0, 3'd3);
        box(0, 8'd0, 8'd0, 8'hFF, 8'd1, 3'd4);
        expect_job(2);
        expect_job(0);
        jobs_left[0] = 1;
        jobs_left[2] = 1;
        upd_req();
        wait_idle(800);

        // Spurious writer done while idle and in S_START is ignored
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("t6_idle_grant", 32'(req_grant), 32'd0);
        box(1, 8'd1, 8'd2, 8'd1, 8'd1, 3'd7);
        expect_job(1);
        jobs_left[1] = 1;
        upd_req();
        tick();
        check("t6_start_state", 32'({req_grant, screen_start}), 32'b0100);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        wait_idle(100);

        // Asynchronous reset five cycles into a job, then a fresh request
        box(2, 8'd0, 8'd0, 8'd20, 8'd0, 3'd1);
        expect_job(2);
        jobs_left[2] = 1;
        upd_req();
        tick_until_start(10);
        repeat (5) tick();
        #2;
        reset = 1'b1;
        #1;
        check("t5_rst_ctrl", 32'({req_grant, req_done, screen_start}), 32'd0);
        check("t5_rst_region", {screen_x_min, screen_y_min, screen_x_range, screen_y_range}, 32'd0);
        check("t5_rst_colour", 32'(new_screen_colour), 32'd0);
        clear_all();
        @(negedge clock);
        reset = 1'b0;
        box(1, 8'd7, 8'd8, 8'd1, 8'd0, 3'd2);
        expect_job(1);
        jobs_left[1] = 1;
        upd_req();
        wait_idle(100);

        check("grant_onehot", 32'(overlap), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
